// File: rtl/round_controller.sv
// Round sequencer for the binary number game: requests a target from the generator,
// runs the per-round countdown, judges guesses and tracks score, lives and game over.
module round_controller #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned ROUND_SECS    = 10,
  parameter int unsigned MAX_LIVES     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       submit,
  input  logic [3:0] guess,
  output logic       gen_enable,
  input  logic [3:0] gen_value,
  output logic [3:0] target,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [3:0] time_left,
  output logic       round_win,
  output logic       round_lose,
  output logic       game_over
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [1:0]    LIVES_INI = 2'(MAX_LIVES);
  localparam logic [3:0]    SECS_INI  = 4'(ROUND_SECS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_PLAY,
    S_OVER
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_start_d;
  logic          r_submit_d;
  logic [TW-1:0] r_tick;
  logic          r_gen_enable;
  logic [3:0]    r_target;
  logic [7:0]    r_score;
  logic [1:0]    r_lives;
  logic [3:0]    r_time_left;
  logic          r_round_win;
  logic          r_round_lose;
  logic          r_game_over;

  logic w_start_edge;
  logic w_submit_edge;
  logic w_wrap;
  logic w_win;
  logic w_lose;

  assign w_start_edge  = start & ~r_start_d;
  assign w_submit_edge = submit & ~r_submit_d;
  assign w_wrap        = (r_tick == TICK_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_win       = 1'b0;
    w_lose      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_edge) w_state_nxt = S_REQ;
      S_REQ:  w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_PLAY;
      S_PLAY: begin
        // A submit edge takes priority over a timeout landing in the same cycle.
        if (w_submit_edge) begin
          if (guess == r_target) w_win = 1'b1;
          else                   w_lose = 1'b1;
        end else if (w_wrap && (r_time_left == 4'd1)) begin
          w_lose = 1'b1;
        end
        if (w_win)       w_state_nxt = S_REQ;
        else if (w_lose) w_state_nxt = (r_lives == 2'd1) ? S_OVER : S_REQ;
      end
      S_OVER: if (w_start_edge) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_start_d    <= 1'b0;
      r_submit_d   <= 1'b0;
      r_tick       <= '0;
      r_gen_enable <= 1'b0;
      r_target     <= '0;
      r_score      <= '0;
      r_lives      <= LIVES_INI;
      r_time_left  <= '0;
      r_round_win  <= 1'b0;
      r_round_lose <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_d    <= start;
      r_submit_d   <= submit;
      r_gen_enable <= (w_state_nxt == S_REQ);
      r_round_win  <= w_win;
      r_round_lose <= w_lose;
      r_game_over  <= (w_state_nxt == S_OVER);
      case (r_state)
        S_LOAD: begin
          r_target    <= gen_value;
          r_time_left <= SECS_INI;
          r_tick      <= '0;
        end
        S_PLAY: begin
          r_tick <= w_wrap ? '0 : r_tick + 1'b1;
          if (w_wrap && (r_time_left != 4'd0)) r_time_left <= r_time_left - 4'd1;
          if (w_win && (r_score != 8'hFF))     r_score     <= r_score + 8'd1;
          if (w_lose)                          r_lives     <= r_lives - 2'd1;
        end
        S_OVER: begin
          if (w_start_edge) begin
            r_score <= '0;
            r_lives <= LIVES_INI;
          end
        end
        default: ;
      endcase
    end
  end

  assign gen_enable = r_gen_enable;
  assign target     = r_target;
  assign score      = r_score;
  assign lives      = r_lives;
  assign time_left  = r_time_left;
  assign round_win  = r_round_win;
  assign round_lose = r_round_lose;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with a 4-tick second, 3-second rounds and 3 lives.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       submit;
  logic [3:0] guess;
  logic       gen_enable;
  logic [3:0] gen_value;
  logic [3:0] target;
  logic [7:0] score;
  logic [1:0] lives;
  logic [3:0] time_left;
  logic       round_win;
  logic       round_lose;
  logic       game_over;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  round_controller #(
    .TICKS_PER_SEC(4),
    .ROUND_SECS   (3),
    .MAX_LIVES    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .submit     (submit),
    .guess      (guess),
    .gen_enable (gen_enable),
    .gen_value  (gen_value),
    .target     (target),
    .score      (score),
    .lives      (lives),
    .time_left  (time_left),
    .round_win  (round_win),
    .round_lose (round_lose),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset, then start a game; returns in the first PLAY cycle with target = v.
  task automatic new_game(input logic [3:0] v);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    gen_value = v;
    start = 1'b1;
    cyc();
    cyc();
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int unsigned cnt;
    rst = 1'b1; start = 1'b0; submit = 1'b0; guess = '0; gen_value = 4'h5;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_gen_en", gen_enable, 0);
    check("rst_target", target, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_time", time_left, 0);
    check("rst_pulses", {round_win, round_lose, game_over}, 0);

    // 1: start edge -> REQ, LOAD, PLAY with target loaded
    start = 1'b1;
    cyc();
    check("t1_req_gen_en", gen_enable, 1);
    check("t1_req_target", target, 0);
    cyc();
    check("t1_load_gen_en", gen_enable, 0);
    cyc();
    check("t1_play_target", target, 5);
    check("t1_play_time", time_left, 3);
    start = 1'b0;

    // 2: correct guess
    guess = 4'd5; submit = 1'b1;
    cyc();
    check("t2_win", round_win, 1);
    check("t2_score", score, 1);
    check("t2_lives", lives, 3);
    check("t2_req", gen_enable, 1);
    submit = 1'b0;
    cyc();
    check("t2_win_1cyc", round_win, 0);
    cyc();

    // 3: wrong guess with submit held
    guess = 4'd6; submit = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (round_lose) cnt++;
    end
    check("t3_lose_count", cnt, 1);
    check("t3_lives", lives, 2);
    check("t3_score", score, 1);
    submit = 1'b0;

    // 4: timeout countdown
    new_game(4'h9);
    guess = 4'd0;
    check("t4_time_k0", time_left, 3);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 3)  check("t4_time_k3", time_left, 3);
      if (k == 4)  check("t4_time_k4", time_left, 2);
      if (k == 8)  check("t4_time_k8", time_left, 1);
      if (k == 11) check("t4_nolose_k11", round_lose, 0);
    end
    check("t4_timeout_lose", round_lose, 1);
    check("t4_timeout_lives", lives, 2);
    check("t4_timeout_time", time_left, 0);
    check("t4_timeout_nowin", round_win, 0);
    cyc();
    check("t4_lose_1cyc", round_lose, 0);

    // 4b: correct submit on the timeout cycle
    new_game(4'h9);
    for (int k = 1; k <= 11; k++) cyc();
    guess = 4'd9; submit = 1'b1;
    cyc();
    check("t4b_win", round_win, 1);
    check("t4b_nolose", round_lose, 0);
    check("t4b_lives", lives, 3);
    check("t4b_score", score, 1);
    submit = 1'b0;

    // 4c: wrong submit on the timeout cycle costs one life only
    new_game(4'h9);
    for (int k = 1; k <= 11; k++) cyc();
    guess = 4'd2; submit = 1'b1;
    cyc();
    check("t4c_lose", round_lose, 1);
    check("t4c_lives", lives, 2);
    submit = 1'b0;

    // 5: start ignored in PLAY, then lose all lives
    new_game(4'h7);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t5_start_ign", gen_enable, 0);
    guess = 4'd7; submit = 1'b1;
    cyc();
    check("t5_score", score, 1);
    submit = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      guess = 4'd0; submit = 1'b1;
      cyc();
      check("t5_lose", round_lose, 1);
      check("t5_lives", lives, 32'(2 - i));
      submit = 1'b0;
      if (i < 2) begin
        cyc();
        cyc();
      end
    end
    check("t5_over", game_over, 1);
    cyc();
    check("t5_over_hold", game_over, 1);
    submit = 1'b1;
    cyc();
    submit = 1'b0;
    cyc();
    check("t5_sub_ign_lives", lives, 0);
    check("t5_over_score", score, 1);
    check("t5_over_target", target, 7);
    check("t5_over_nowin", round_win, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t5_restart_score", score, 0);
    check("t5_restart_lives", lives, 3);
    check("t5_restart_req", gen_enable, 1);
    check("t5_restart_over", game_over, 0);

    // 6: score saturation
    new_game(4'h3);
    guess = 4'd3;
    for (int i = 0; i < 255; i++) begin
      submit = 1'b1;
      cyc();
      submit = 1'b0;
      cyc();
      cyc();
    end
    check("t6_score255", score, 255);
    submit = 1'b1;
    cyc();
    submit = 1'b0;
    check("t6_sat_win", round_win, 1);
    check("t6_sat_score", score, 255);
    cyc();
    cyc();

    // 6b: asynchronous reset mid-PLAY
    #2 rst = 1'b1;
    #1;
    check("t6_arst_target", target, 0);
    check("t6_arst_score", score, 0);
    check("t6_arst_lives", lives, 3);
    check("t6_arst_time", time_left, 0);
    check("t6_arst_flags", {gen_enable, round_win, round_lose, game_over}, 0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    check("t6_idle_no_req", gen_enable, 0);
    gen_value = 4'hA;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t6_idle_start", gen_enable, 1);

    // 6c: reset during REQ drops gen_enable with no target load
    #2 rst = 1'b1;
    #1;
    check("t6c_gen_drop", gen_enable, 0);
    cyc();
    cyc();
    check("t6c_no_load", target, 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
